// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_arb_pkg
//  Purpose  : Shared widths, write-back entry type and register-match helper
//             for the register-file write arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package rf_arb_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [XLEN-1:0]   wd;
    } rf_wb_entry_t;

    // x0 is hard-wired, so it never counts as a match.
    function automatic logic reg_hit(input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
        return (a == b) && (b != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_fifo
//  Purpose  : Strict-order FIFO of write-back entries with a per-entry
//             valid/address view for pending-register lookups.
//  Revision : 1.0  initial release
// ============================================================================
module rf_wb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  rf_wb_entry_t                  i_entry,
    input  logic                          i_pop,
    output rf_wb_entry_t                  o_head,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [DEPTH-1:0]              o_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]  o_wa
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    rf_wb_entry_t     r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CW'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
    end

    // An entry is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [c_PW-1:0] w_offs;
        assign w_offs     = c_PW'(i) - r_rd_ptr;
        assign o_valid[i] = ({1'b0, w_offs} < r_count);
        assign o_wa[i]    = r_mem[i].wa;
    end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_write_arbiter
//  Purpose  : Shares the register-file write port between pipeline write-back
//             and buffered long-latency results; drives bypass and pending
//             flags. Optional starvation guard: RF_ARB_STARVE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pl_we,
    input  logic [REG_AW-1:0] pl_wa,
    input  logic [XLEN-1:0]   pl_wd,
    input  logic              ll_valid,
    output logic              ll_ready,
    input  logic [REG_AW-1:0] ll_wa,
    input  logic [XLEN-1:0]   ll_wd,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic [REG_AW-1:0] dec_rd,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [XLEN-1:0]   rf_wd,
    output logic              wb2d_a,
    output logic              wb2d_b,
    output logic [XLEN-1:0]   wb_val,
    output logic              pend_a,
    output logic              pend_b,
    output logic              pend_d,
    output logic              pl_stall
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_bad_param
        $error("rf_write_arbiter: illegal FIFO_DEPTH/STARVE_MAX");
    end

    rf_wb_entry_t                      w_head;
    logic                              w_empty;
    logic                              w_full;
    logic [FIFO_DEPTH-1:0]             w_valid;
    logic [FIFO_DEPTH-1:0][REG_AW-1:0] w_fifo_wa;
    logic                              w_push;
    logic                              w_pop;
    logic                              w_pl_win;
    logic                              w_stall;
    logic [FIFO_DEPTH-1:0]             w_hit_a;
    logic [FIFO_DEPTH-1:0]             w_hit_b;
    logic [FIFO_DEPTH-1:0]             w_hit_d;

    // Both outputs are held low while reset is asserted, not just after it.
    assign ll_ready = !rst && !w_full;
    assign w_push   = ll_valid && ll_ready && (ll_wa != '0);
    assign w_pl_win = !rst && !w_stall && pl_we && (pl_wa != '0);
    assign w_pop    = !rst && !w_pl_win && !w_empty;

    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry ('{wa: ll_wa, wd: ll_wd}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_valid (w_valid),
        .o_wa    (w_fifo_wa)
    );

    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (w_pl_win) begin
            rf_we = 1'b1;
            rf_wa = pl_wa;
            rf_wd = pl_wd;
        end else if (w_pop) begin
            rf_we = 1'b1;
            rf_wa = w_head.wa;
            rf_wd = w_head.wd;
        end
    end

    assign wb2d_a = rf_we && reg_hit(rf_wa, ra1);
    assign wb2d_b = rf_we && reg_hit(rf_wa, ra2);
    assign wb_val = rf_wd;

    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_pend
        assign w_hit_a[i] = w_valid[i] && reg_hit(w_fifo_wa[i], ra1);
        assign w_hit_b[i] = w_valid[i] && reg_hit(w_fifo_wa[i], ra2);
        assign w_hit_d[i] = w_valid[i] && reg_hit(w_fifo_wa[i], dec_rd);
    end

    assign pend_a = |w_hit_a;
    assign pend_b = |w_hit_b;
    assign pend_d = |w_hit_d;

`ifdef RF_ARB_STARVE_EN
    localparam int c_SCW = $clog2(STARVE_MAX + 1);

    logic [c_SCW-1:0] r_starve_cnt;
    logic             r_pl_stall;
    logic             w_blocked;
    logic             w_fire;

    assign w_blocked = w_pl_win && !w_empty;
    assign w_fire    = w_blocked && (r_starve_cnt == c_SCW'(STARVE_MAX - 1));

    // The stall cycle always pops the head, which clears the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_pl_stall   <= 1'b0;
        end else begin
            r_pl_stall <= w_fire;
            if (w_pop)
                r_starve_cnt <= '0;
            else if (w_blocked)
                r_starve_cnt <= r_starve_cnt + c_SCW'(1);
        end
    end

    assign w_stall = r_pl_stall;
`else
    assign w_stall = 1'b0;
`endif

    assign pl_stall = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_write_arbiter
//  Purpose  : Directed vector table plus hand-written reset and starvation
//             sequences for rf_write_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_write_arbiter;

    typedef struct {
        logic        pl_we;
        logic [4:0]  pl_wa;
        logic [31:0] pl_wd;
        logic        ll_valid;
        logic [4:0]  ll_wa;
        logic [31:0] ll_wd;
        logic [4:0]  ra1, ra2, dec_rd;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_rdy, e_fa, e_fb, e_pa, e_pb, e_pd;
    } vec_t;

    logic        clk, rst;
    logic        pl_we, ll_valid, ll_ready;
    logic [4:0]  pl_wa, ll_wa, ra1, ra2, dec_rd, rf_wa;
    logic [31:0] pl_wd, ll_wd, rf_wd, wb_val;
    logic        rf_we, wb2d_a, wb2d_b, pend_a, pend_b, pend_d, pl_stall;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vt[10];

    rf_write_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .pl_we(pl_we), .pl_wa(pl_wa), .pl_wd(pl_wd),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_wa(ll_wa), .ll_wd(ll_wd),
        .ra1(ra1), .ra2(ra2), .dec_rd(dec_rd),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .wb2d_a(wb2d_a), .wb2d_b(wb2d_b), .wb_val(wb_val),
        .pend_a(pend_a), .pend_b(pend_b), .pend_d(pend_d),
        .pl_stall(pl_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dr);
        pl_we = pw; pl_wa = pa; pl_wd = pd;
        ll_valid = lv; ll_wa = la; ll_wd = ld;
        ra1 = r1; ra2 = r2; dec_rd = dr;
    endtask

    function automatic vec_t mk(logic pw, logic [4:0] pa, logic [31:0] pd,
                                logic lv, logic [4:0] la, logic [31:0] ld,
                                logic [4:0] r1, logic [4:0] r2, logic [4:0] dr,
                                logic we, logic [4:0] wa, logic [31:0] wd,
                                logic rdy, logic fa, logic fb,
                                logic pa_, logic pb_, logic pd_);
        vec_t v;
        v.pl_we = pw; v.pl_wa = pa; v.pl_wd = pd;
        v.ll_valid = lv; v.ll_wa = la; v.ll_wd = ld;
        v.ra1 = r1; v.ra2 = r2; v.dec_rd = dr;
        v.e_we = we; v.e_wa = wa; v.e_wd = wd;
        v.e_rdy = rdy; v.e_fa = fa; v.e_fb = fb;
        v.e_pa = pa_; v.e_pb = pb_; v.e_pd = pd_;
        return v;
    endfunction

    initial begin
        // Consecutive cycles starting from an empty FIFO; each row is checked before its edge.
        //          pl_we wa  wd        llv wa  wd         ra1 ra2 rd  we wa  wd         rdy fa fb pa pb pd
        vt[0] = mk(0, 0,  32'h0,     1, 7,  32'hDEAD,  7,  0,  0,  0, 0,  32'h0,     1, 0, 0, 0, 0, 0);
        vt[1] = mk(0, 0,  32'h0,     0, 0,  32'h0,     7,  3,  0,  1, 7,  32'hDEAD,  1, 1, 0, 1, 0, 0);
        vt[2] = mk(1, 4,  32'h44,    1, 5,  32'h55,    5,  0,  0,  1, 4,  32'h44,    1, 0, 0, 0, 0, 0);
        vt[3] = mk(1, 4,  32'h45,    1, 6,  32'h66,    5,  6,  5,  1, 4,  32'h45,    1, 0, 0, 1, 0, 1);
        vt[4] = mk(1, 4,  32'h46,    1, 8,  32'h88,    5,  6,  8,  1, 4,  32'h46,    0, 0, 0, 1, 1, 0);
        vt[5] = mk(0, 0,  32'h0,     1, 8,  32'h88,    5,  0,  0,  1, 5,  32'h55,    0, 1, 0, 1, 0, 0);
        vt[6] = mk(1, 0,  32'hBAD,   1, 9,  32'h99,    0,  6,  0,  1, 6,  32'h66,    1, 0, 1, 0, 1, 0);
        vt[7] = mk(1, 0,  32'hBAD,   0, 0,  32'h0,     9,  0,  0,  1, 9,  32'h99,    1, 1, 0, 1, 0, 0);
        vt[8] = mk(1, 0,  32'hBAD,   1, 0,  32'h77,    0,  0,  0,  0, 0,  32'h0,     1, 0, 0, 0, 0, 0);
        vt[9] = mk(0, 0,  32'h0,     0, 0,  32'h0,     0,  0,  0,  0, 0,  32'h0,     1, 0, 0, 0, 0, 0);

        // Reset held with live requests on both sides.
        rst = 1'b1;
        drive(1, 3, 32'h33, 1, 2, 32'h22, 0, 0, 0);
        #2;
        chk("rst rf_we", rf_we, 0);
        chk("rst ll_ready", ll_ready, 0);
        chk("rst pl_stall", pl_stall, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vt[i].pl_we, vt[i].pl_wa, vt[i].pl_wd, vt[i].ll_valid, vt[i].ll_wa,
                  vt[i].ll_wd, vt[i].ra1, vt[i].ra2, vt[i].dec_rd);
            #2;
            chk($sformatf("v%0d rf_we", i), rf_we, vt[i].e_we);
            if (vt[i].e_we) begin
                chk($sformatf("v%0d rf_wa", i), rf_wa, vt[i].e_wa);
                chk($sformatf("v%0d rf_wd", i), rf_wd, vt[i].e_wd);
                chk($sformatf("v%0d wb_val", i), wb_val, vt[i].e_wd);
            end
            chk($sformatf("v%0d ll_ready", i), ll_ready, vt[i].e_rdy);
            chk($sformatf("v%0d wb2d_a", i), wb2d_a, vt[i].e_fa);
            chk($sformatf("v%0d wb2d_b", i), wb2d_b, vt[i].e_fb);
            chk($sformatf("v%0d pend_a", i), pend_a, vt[i].e_pa);
            chk($sformatf("v%0d pend_b", i), pend_b, vt[i].e_pb);
            chk($sformatf("v%0d pend_d", i), pend_d, vt[i].e_pd);
        end

        // Fill the FIFO behind pipeline traffic, then reset mid-traffic.
        @(negedge clk); drive(1, 4, 32'h1, 1, 10, 32'hA0, 10, 11, 0);
        @(negedge clk); drive(1, 4, 32'h2, 1, 11, 32'hB0, 10, 11, 0);
        @(negedge clk); drive(1, 4, 32'h3, 1, 12, 32'hC0, 10, 11, 0);
        #2;
        chk("fill ll_ready", ll_ready, 0);
        chk("fill pend_a", pend_a, 1);
        chk("fill pend_b", pend_b, 1);
        rst = 1'b1;
        #1;
        chk("midrst rf_we", rf_we, 0);
        chk("midrst ll_ready", ll_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 10, 11, 10);
        #2;
        chk("postrst rf_we", rf_we, 0);
        chk("postrst pend_a", pend_a, 0);
        chk("postrst pend_b", pend_b, 0);
        chk("postrst pend_d", pend_d, 0);
        chk("postrst ll_ready", ll_ready, 1);

        // Starvation: one LL entry held behind continuous pipeline writes.
        @(negedge clk); drive(1, 4, 32'h40, 1, 12, 32'hC12, 0, 0, 0);
`ifdef RF_ARB_STARVE_EN
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); drive(1, 4, 32'h40 + c, 0, 0, 0, 0, 0, 0);
            #2;
            chk($sformatf("starve c%0d pl_stall", c), pl_stall, (c == 5) ? 1 : 0);
            chk($sformatf("starve c%0d rf_wa", c), rf_wa, (c == 5) ? 12 : 4);
            chk($sformatf("starve c%0d rf_wd", c), rf_wd, (c == 5) ? 32'hC12 : 32'h40 + c);
        end
`else
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); drive(1, 4, 32'h40 + c, 0, 0, 0, 0, 0, 0);
            #2;
            chk($sformatf("nostarve c%0d pl_stall", c), pl_stall, 0);
            chk($sformatf("nostarve c%0d rf_wa", c), rf_wa, 4);
        end
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("nostarve drain rf_wa", rf_wa, 12);
        chk("nostarve drain rf_wd", rf_wd, 32'hC12);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
